// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock.
// Latency: start sampled at edge N -> busy for cycles N+1..N+WIDTH, done pulse in cycle N+WIDTH+1.
// Backpressure: none; start is ignored while busy and accepted in IDLE or in the DONE cycle.
//
// Ports:
//   clk, rst       single clock, asynchronous active-high reset
//   start          request a new subtraction (accepted when not busy)
//   a, b, bin      minuend, subtrahend, borrow-in (captured on acceptance)
//   diff, bout     registered result and borrow-out, held until the next completion
//   busy, done     state decodes: RUN and the single-cycle DONE state
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic             bout_q;
  logic [CW-1:0]    cnt_q;

  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  // Operand registers shift right so bit 0 is always the bit being processed.
  assign bit_d = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  // Result bits enter at the MSB; after WIDTH shifts the first bit lands in bit 0.
  assign res_d = {bit_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  int total;
  int bad;

  logic [W-1:0] prev_diff;
  logic         prev_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, wrapped to W bits; borrow when negative.
  function automatic logic [W:0] model(input int av, input int bv, input int binv);
    int r;
    r = av - bv - binv;
    model = {(r < 0), W'(r & ((1 << W) - 1))};
  endfunction

  // Called at a negedge in IDLE. Optionally disturbs start/a/b/bin during RUN.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic binv, input bit disturb);
    logic [W:0] e;
    e = model(int'(av), int'(bv), int'(binv));
    a = av; b = bv; bin = binv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".nodone"}, 32'(done), 32'd0);
      chk({tag, ".hold"}, 32'({prev_bout, prev_diff}), 32'({bout, diff}));
      if (disturb) begin
        start = (i == 0 || i == 1);
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
      end
      @(negedge clk);
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_lo"}, 32'(busy), 32'd0);
    chk({tag, ".res"}, 32'({bout, diff}), 32'(e));
    prev_diff = e[W-1:0];
    prev_bout = e[W];
    @(negedge clk);
    chk({tag, ".once"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    logic [W:0] e;
    total = 0;
    bad = 0;
    prev_diff = '0;
    prev_bout = 1'b0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.outs", 32'({diff, bout, busy, done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.outs", 32'({diff, bout, busy, done}), 32'd0);

    // Directed worked examples
    run_op("d0", 4'b0101, 4'b0011, 1'b0, 1'b0);
    run_op("d1", 4'b0011, 4'b0101, 1'b0, 1'b0);
    run_op("d2", 4'b0110, 4'b0101, 1'b1, 1'b0);
    run_op("d3", 4'b1111, 4'b1111, 1'b1, 1'b0);
    run_op("d4", 4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("d4.allones", 32'({bout, diff}), 32'h1F);

    // start and operand changes during RUN are ignored
    run_op("ign", 4'b1010, 4'b0011, 1'b0, 1'b1);

    // Continuous start: back-to-back, done every 5th cycle
    e = model(8, 1, 0);
    a = 4'b1000; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < W; i++) begin
        chk("b2b.busy", 32'({busy, done}), 32'b10);
        @(negedge clk);
      end
      chk("b2b.done", 32'({busy, done}), 32'b01);
      chk("b2b.res", 32'({bout, diff}), 32'(e));
      if (k == 2) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b.idle", 32'({busy, done}), 32'd0);
    prev_diff = e[W-1:0];
    prev_bout = e[W];

    // Asynchronous reset in the middle of RUN
    a = 4'b0111; b = 4'b0010; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("arst.now", 32'({diff, bout, busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("arst.quiet", 32'({diff, bout, busy, done}), 32'd0);
      @(negedge clk);
    end
    prev_diff = '0;
    prev_bout = 1'b0;
    run_op("post", 4'b0111, 4'b0010, 1'b1, 1'b0);

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 20; n++) begin
      run_op("rnd", W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
